// File: rtl/bsg_dmc_pkg.sv
// Shared types for the DMC clock/delay-line configuration sequencer.
package bsg_dmc_pkg;

  typedef enum logic [2:0] {
    OSC_RESET = 3'd0,
    DLY_RESET = 3'd1,
    DS_RESET  = 3'd2,
    OSC       = 3'd3,
    OSC_TRIG  = 3'd4,
    SEL       = 3'd5,
    DLY       = 3'd6,
    DLY_TRIG  = 3'd7
  } bsg_dmc_cfg_target_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } bsg_dmc_clk_cfg_state_e;

  // Writes that do not depend on the number of DQS groups.
  localparam int unsigned fixed_writes_lp = 10;

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear; clear takes priority over increment.
module bsg_counter_clear_up #(
  parameter int unsigned max_val_p = 15,
  parameter int unsigned width_p   = (max_val_p > 0) ? $clog2(max_val_p + 1) : 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)   count_o <= '0;
    else if (clear_i) count_o <= '0;
    else if (up_i)    count_o <= count_o + 1'b1;
  end

endmodule

// File: rtl/bsg_dmc_clk_cfg_seq.sv
// Issues the ordered oscillator/DQS delay-line configuration writes after a
// start pulse, then waits a fixed number of cycles for the clocks to settle.
module bsg_dmc_clk_cfg_seq
  import bsg_dmc_pkg::*;
#(
  parameter int unsigned dq_group_p      = 2,
  parameter int unsigned dly_width_p     = 8,
  parameter int unsigned settle_cycles_p = 16,
  localparam int unsigned idx_width_lp   = (dq_group_p > 1) ? $clog2(dq_group_p) : 1
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              start_i,
  input  logic [dly_width_p-1:0]            osc_val_i,
  input  logic [1:0]                        sel_val_i,
  input  logic [dq_group_p*dly_width_p-1:0] dly_val_i,
  output logic                              cfg_v_o,
  input  logic                              cfg_ready_i,
  output bsg_dmc_cfg_target_e               cfg_target_o,
  output logic [idx_width_lp-1:0]           cfg_idx_o,
  output logic [dly_width_p-1:0]            cfg_data_o,
  output logic                              busy_o,
  output logic                              done_o
);

  localparam int unsigned total_writes_lp = fixed_writes_lp + 3 * dq_group_p;
  localparam int unsigned cnt_width_lp    = $clog2(total_writes_lp);
  localparam int unsigned settle_max_lp   = settle_cycles_p - 1;
  localparam int unsigned settle_width_lp = (settle_max_lp > 0) ? $clog2(settle_max_lp + 1) : 1;

  bsg_dmc_clk_cfg_state_e state_r, state_n;

  logic [cnt_width_lp-1:0]           wr_cnt_r;
  logic [dly_width_p-1:0]            osc_r;
  logic [1:0]                        sel_r;
  logic [dq_group_p*dly_width_p-1:0] dly_r;
  logic [settle_width_lp-1:0]        settle_cnt;
  logic [31:0]                       n;

  logic start_accept, xfer, last_write, settle_last;

  assign start_accept = start_i && ((state_r == IDLE) || (state_r == DONE));
  assign xfer         = (state_r == WRITE) && cfg_ready_i;
  assign last_write   = (wr_cnt_r == cnt_width_lp'(total_writes_lp - 1));
  assign settle_last  = (settle_cnt == settle_width_lp'(settle_max_lp));

  assign cfg_v_o = (state_r == WRITE);
  assign busy_o  = (state_r == WRITE) || (state_r == SETTLE);
  assign done_o  = (state_r == DONE);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= IDLE;
    else            state_r <= state_n;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)        wr_cnt_r <= '0;
    else if (start_accept) wr_cnt_r <= '0;
    else if (xfer)         wr_cnt_r <= last_write ? '0 : wr_cnt_r + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      osc_r <= '0;
      sel_r <= '0;
      dly_r <= '0;
    end else if (start_accept) begin
      osc_r <= osc_val_i;
      sel_r <= sel_val_i;
      dly_r <= dly_val_i;
    end
  end

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      IDLE, DONE: if (start_i)                   state_n = WRITE;
      WRITE:      if (cfg_ready_i && last_write) state_n = SETTLE;
      SETTLE:     if (settle_last)               state_n = DONE;
      default:                                   state_n = IDLE;
    endcase
  end

  // Settle counter sits at zero until SETTLE is entered, so the first
  // SETTLE cycle already counts as cycle 0.
  bsg_counter_clear_up #(
    .max_val_p (settle_max_lp),
    .width_p   (settle_width_lp)
  ) settle_counter (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (state_r != SETTLE),
    .up_i      (state_r == SETTLE),
    .count_o   (settle_cnt)
  );

  assign n = 32'(wr_cnt_r);

  // Outputs are forced to their reset values outside WRITE.
  always_comb begin
    cfg_target_o = OSC_RESET;
    cfg_idx_o    = '0;
    cfg_data_o   = '0;
    if (state_r == WRITE) begin
      case (n)
        32'd0:   begin cfg_target_o = OSC_RESET; cfg_data_o = dly_width_p'(1); end
        32'd1:   begin cfg_target_o = DLY_RESET; cfg_data_o = dly_width_p'(1); end
        32'd2:   begin cfg_target_o = DS_RESET;  cfg_data_o = dly_width_p'(1); end
        32'd3:   cfg_target_o = OSC_RESET;
        32'd4:   cfg_target_o = DLY_RESET;
        32'd5:   begin cfg_target_o = OSC;       cfg_data_o = osc_r; end
        32'd6:   begin cfg_target_o = OSC_TRIG;  cfg_data_o = dly_width_p'(1); end
        32'd7:   cfg_target_o = OSC_TRIG;
        32'd8:   begin cfg_target_o = SEL;       cfg_data_o = dly_width_p'(sel_r); end
        default: ;
      endcase
      for (int unsigned g = 0; g < dq_group_p; g++) begin
        if (n == 9 + 3 * g) begin
          cfg_target_o = DLY;
          cfg_idx_o    = idx_width_lp'(g);
          cfg_data_o   = dly_r[g*dly_width_p +: dly_width_p];
        end
        if (n == 10 + 3 * g) begin
          cfg_target_o = DLY_TRIG;
          cfg_idx_o    = idx_width_lp'(g);
          cfg_data_o   = dly_width_p'(1);
        end
        if (n == 11 + 3 * g) begin
          cfg_target_o = DLY_TRIG;
          cfg_idx_o    = idx_width_lp'(g);
        end
      end
      if (n == total_writes_lp - 1) cfg_target_o = DS_RESET;
    end
  end

endmodule

// File: tb/tb_bsg_dmc_clk_cfg_seq.sv
// Directed bench for bsg_dmc_clk_cfg_seq with two DQS groups and 16 settle cycles.
module tb_bsg_dmc_clk_cfg_seq;
  import bsg_dmc_pkg::*;

  localparam int unsigned G  = 2;
  localparam int unsigned W  = 8;
  localparam int unsigned S  = 16;
  localparam int          NW = 16;

  logic                clk_i = 1'b0;
  logic                reset_n_i;
  logic                start_i;
  logic [W-1:0]        osc_val_i;
  logic [1:0]          sel_val_i;
  logic [G*W-1:0]      dly_val_i;
  logic                cfg_v_o;
  logic                cfg_ready_i;
  bsg_dmc_cfg_target_e cfg_target_o;
  logic [0:0]          cfg_idx_o;
  logic [W-1:0]        cfg_data_o;
  logic                busy_o;
  logic                done_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  bsg_dmc_clk_cfg_seq #(
    .dq_group_p      (G),
    .dly_width_p     (W),
    .settle_cycles_p (S)
  ) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .start_i      (start_i),
    .osc_val_i    (osc_val_i),
    .sel_val_i    (sel_val_i),
    .dly_val_i    (dly_val_i),
    .cfg_v_o      (cfg_v_o),
    .cfg_ready_i  (cfg_ready_i),
    .cfg_target_o (cfg_target_o),
    .cfg_idx_o    (cfg_idx_o),
    .cfg_data_o   (cfg_data_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  bsg_dmc_cfg_target_e exp_tgt [NW] = '{
    OSC_RESET, DLY_RESET, DS_RESET, OSC_RESET, DLY_RESET, OSC, OSC_TRIG, OSC_TRIG,
    SEL, DLY, DLY_TRIG, DLY_TRIG, DLY, DLY_TRIG, DLY_TRIG, DS_RESET};
  logic [0:0] exp_idx [NW] = '{
    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  function automatic logic [W-1:0] exp_data(input int n, input logic [W-1:0] osc,
                                            input logic [1:0] sel, input logic [G*W-1:0] dly);
    case (n)
      0, 1, 2, 6, 10, 13: return 8'h01;
      5:                  return osc;
      8:                  return {6'b0, sel};
      9:                  return dly[7:0];
      12:                 return dly[15:8];
      default:            return 8'h00;
    endcase
  endfunction

  task automatic pulse_start();
    @(posedge clk_i); #1 start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0; start_i = 1'b0; cfg_ready_i = 1'b1;
    osc_val_i = '0; sel_val_i = '0; dly_val_i = '0;
    #12;
    checks++;
    if (cfg_v_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || cfg_target_o !== OSC_RESET ||
        cfg_idx_o !== 1'b0 || cfg_data_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: v=%b busy=%b done=%b tgt=%0d idx=%0d data=%h, expected all zero",
               cfg_v_o, busy_o, done_o, cfg_target_o, cfg_idx_o, cfg_data_o);
    end
    @(negedge clk_i); reset_n_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      checks++;
      if (cfg_v_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset cycle %0d: v=%b busy=%b done=%b, expected 0 0 0",
                 c, cfg_v_o, busy_o, done_o);
      end
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] osc = 8'h5A; logic [1:0] sel = 2'b10; logic [G*W-1:0] dly = 16'h3344;
    osc_val_i = osc; sel_val_i = sel; dly_val_i = dly;
    pulse_start();
    for (int n = 0; n < NW; n++) begin
      @(negedge clk_i);
      checks++;
      if (cfg_v_o !== 1'b1 || busy_o !== 1'b1 || done_o !== 1'b0 || cfg_target_o !== exp_tgt[n] ||
          cfg_idx_o !== exp_idx[n] || cfg_data_o !== exp_data(n, osc, sel, dly)) begin
        errors++;
        $display("FAIL basic_write %0d: v=%b busy=%b done=%b tgt=%0d idx=%0d data=%h, expected v=1 busy=1 done=0 tgt=%0d idx=%0d data=%h",
                 n, cfg_v_o, busy_o, done_o, cfg_target_o, cfg_idx_o, cfg_data_o,
                 exp_tgt[n], exp_idx[n], exp_data(n, osc, sel, dly));
      end
    end
    for (int c = 0; c < int'(S); c++) begin
      @(negedge clk_i);
      checks++;
      if (cfg_v_o !== 1'b0 || busy_o !== 1'b1 || done_o !== 1'b0) begin
        errors++;
        $display("FAIL basic_settle cycle %0d: v=%b busy=%b done=%b, expected 0 1 0", c, cfg_v_o, busy_o, done_o);
      end
    end
    @(negedge clk_i);
    checks++;
    if (cfg_v_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b1) begin
      errors++;
      $display("FAIL basic_done: v=%b busy=%b done=%b, expected 0 0 1", cfg_v_o, busy_o, done_o);
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] osc = 8'h5A; logic [1:0] sel = 2'b01; logic [G*W-1:0] dly = 16'h7788;
    int n = 0, stall = 0, seen = 0;
    osc_val_i = osc; sel_val_i = sel; dly_val_i = dly;
    pulse_start();
    for (int c = 0; c < 30 && n < NW; c++) begin
      @(negedge clk_i);
      checks++;
      if (cfg_v_o !== 1'b1 || busy_o !== 1'b1 || cfg_target_o !== exp_tgt[n] ||
          cfg_idx_o !== exp_idx[n] || cfg_data_o !== exp_data(n, osc, sel, dly)) begin
        errors++;
        $display("FAIL stall_write %0d (cycle %0d): v=%b busy=%b tgt=%0d idx=%0d data=%h, expected v=1 busy=1 tgt=%0d idx=%0d data=%h",
                 n, c, cfg_v_o, busy_o, cfg_target_o, cfg_idx_o, cfg_data_o,
                 exp_tgt[n], exp_idx[n], exp_data(n, osc, sel, dly));
      end
      if (n == 5 && stall < 3) begin cfg_ready_i = 1'b0; stall++; end
      else begin cfg_ready_i = 1'b1; n++; end
    end
    cfg_ready_i = 1'b1;
    checks++;
    if (n != NW || stall != 3) begin
      errors++;
      $display("FAIL stall_progress: writes=%0d stalls=%0d, expected %0d and 3", n, stall, NW);
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (done_o === 1'b1) begin seen = 1; break; end
    end
    checks++;
    if (seen != 1) begin errors++; $display("FAIL stall_done: done_o=%b, expected 1 within 40 cycles", done_o); end
  endtask

  task automatic test_latch();
    logic [W-1:0] osc = 8'h5A; logic [1:0] sel = 2'b01; logic [G*W-1:0] dly = 16'hA5C3;
    int seen = 0;
    osc_val_i = osc; sel_val_i = sel; dly_val_i = dly;
    pulse_start();
    osc_val_i = 8'h11; sel_val_i = 2'b10; dly_val_i = 16'h0000;
    for (int n = 0; n < NW; n++) begin
      @(negedge clk_i);
      checks++;
      if (cfg_v_o !== 1'b1 || cfg_target_o !== exp_tgt[n] || cfg_idx_o !== exp_idx[n] ||
          cfg_data_o !== exp_data(n, osc, sel, dly)) begin
        errors++;
        $display("FAIL latch_write %0d: v=%b tgt=%0d idx=%0d data=%h, expected v=1 tgt=%0d idx=%0d data=%h",
                 n, cfg_v_o, cfg_target_o, cfg_idx_o, cfg_data_o, exp_tgt[n], exp_idx[n], exp_data(n, osc, sel, dly));
      end
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (done_o === 1'b1) begin seen = 1; break; end
    end
    checks++;
    if (seen != 1) begin errors++; $display("FAIL latch_done: done_o=%b, expected 1 within 40 cycles", done_o); end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] osc = 8'h42; logic [1:0] sel = 2'b11; logic [G*W-1:0] dly = 16'h0F0E;
    osc_val_i = osc; sel_val_i = sel; dly_val_i = dly;
    pulse_start();
    for (int n = 0; n < NW; n++) begin
      @(negedge clk_i);
      checks++;
      if (cfg_v_o !== 1'b1 || cfg_target_o !== exp_tgt[n] || cfg_idx_o !== exp_idx[n] ||
          cfg_data_o !== exp_data(n, osc, sel, dly)) begin
        errors++;
        $display("FAIL ignore_write %0d: v=%b tgt=%0d idx=%0d data=%h, expected v=1 tgt=%0d idx=%0d data=%h",
                 n, cfg_v_o, cfg_target_o, cfg_idx_o, cfg_data_o, exp_tgt[n], exp_idx[n], exp_data(n, osc, sel, dly));
      end
      start_i = (n == 2);
    end
    for (int c = 0; c < int'(S); c++) begin
      @(negedge clk_i);
      checks++;
      if (cfg_v_o !== 1'b0 || busy_o !== 1'b1 || done_o !== 1'b0) begin
        errors++;
        $display("FAIL ignore_settle cycle %0d: v=%b busy=%b done=%b, expected 0 1 0", c, cfg_v_o, busy_o, done_o);
      end
      start_i = (c == 5);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      checks++;
      if (cfg_v_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b1) begin
        errors++;
        $display("FAIL ignore_done cycle %0d: v=%b busy=%b done=%b, expected 0 0 1", c, cfg_v_o, busy_o, done_o);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] osc = 8'h99; logic [1:0] sel = 2'b00; logic [G*W-1:0] dly = 16'h5566;
    int seen = 0;
    osc_val_i = osc; sel_val_i = sel; dly_val_i = dly;
    pulse_start();
    for (int n = 0; n < 12; n++) begin
      @(negedge clk_i);
      checks++;
      if (cfg_v_o !== 1'b1 || cfg_target_o !== exp_tgt[n] || cfg_data_o !== exp_data(n, osc, sel, dly)) begin
        errors++;
        $display("FAIL midreset_write %0d: v=%b tgt=%0d data=%h, expected v=1 tgt=%0d data=%h",
                 n, cfg_v_o, cfg_target_o, cfg_data_o, exp_tgt[n], exp_data(n, osc, sel, dly));
      end
    end
    cfg_ready_i = 1'b0;
    #2 reset_n_i = 1'b0;
    #1;
    checks++;
    if (cfg_v_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || cfg_target_o !== OSC_RESET || cfg_data_o !== 8'h00) begin
      errors++;
      $display("FAIL midreset_async: v=%b busy=%b done=%b tgt=%0d data=%h, expected 0 0 0 0 00",
               cfg_v_o, busy_o, done_o, cfg_target_o, cfg_data_o);
    end
    @(negedge clk_i);
    reset_n_i = 1'b1; cfg_ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      checks++;
      if (cfg_v_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL midreset_idle cycle %0d: v=%b busy=%b, expected 0 0", c, cfg_v_o, busy_o);
      end
    end
    pulse_start();
    for (int n = 0; n < NW; n++) begin
      @(negedge clk_i);
      checks++;
      if (cfg_v_o !== 1'b1 || cfg_target_o !== exp_tgt[n] || cfg_idx_o !== exp_idx[n] ||
          cfg_data_o !== exp_data(n, osc, sel, dly)) begin
        errors++;
        $display("FAIL midreset_restart_write %0d: v=%b tgt=%0d idx=%0d data=%h, expected v=1 tgt=%0d idx=%0d data=%h",
                 n, cfg_v_o, cfg_target_o, cfg_idx_o, cfg_data_o, exp_tgt[n], exp_idx[n], exp_data(n, osc, sel, dly));
      end
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (done_o === 1'b1) begin seen = 1; break; end
    end
    checks++;
    if (seen != 1) begin errors++; $display("FAIL midreset_done: done_o=%b, expected 1 within 40 cycles", done_o); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] osc = 8'h3C; logic [1:0] sel = 2'b11; logic [G*W-1:0] dly = 16'h2010;
    int seen = 0;
    osc_val_i = osc; sel_val_i = sel; dly_val_i = dly;
    checks++;
    if (done_o !== 1'b1) begin errors++; $display("FAIL b2b_precondition: done_o=%b, expected 1", done_o); end
    pulse_start();
    for (int n = 0; n < NW; n++) begin
      @(negedge clk_i);
      checks++;
      if (cfg_v_o !== 1'b1 || busy_o !== 1'b1 || done_o !== 1'b0 || cfg_target_o !== exp_tgt[n] ||
          cfg_idx_o !== exp_idx[n] || cfg_data_o !== exp_data(n, osc, sel, dly)) begin
        errors++;
        $display("FAIL b2b_write %0d: v=%b busy=%b done=%b tgt=%0d idx=%0d data=%h, expected v=1 busy=1 done=0 tgt=%0d idx=%0d data=%h",
                 n, cfg_v_o, busy_o, done_o, cfg_target_o, cfg_idx_o, cfg_data_o,
                 exp_tgt[n], exp_idx[n], exp_data(n, osc, sel, dly));
      end
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (done_o === 1'b1) begin seen = 1; break; end
    end
    checks++;
    if (seen != 1) begin errors++; $display("FAIL b2b_done: done_o=%b, expected 1 within 40 cycles", done_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_latch();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsg_dmc_clk_cfg_seq.md
BSG_DMC_CLK_CFG_SEQ -- requirements
Module: bsg_dmc_clk_cfg_seq

Interface
REQ-001 SHALL have parameter dq_group_p, default 2: number of DQS delay lines to program; legal range 1-8.
REQ-002 SHALL have parameter dly_width_p, default 8: width of the delay-line and oscillator setting.
REQ-003 SHALL have parameter settle_cycles_p, default 16: clock-settle wait in cycles; legal range 1-1024.
REQ-004 clk_i  in  1  sole clock.
REQ-005 reset_n_i  in  1  asynchronous, active-low reset.
REQ-006 start_i  in  1  start-sequence pulse.
REQ-007 osc_val_i  in  dly_width_p  oscillator setting.
REQ-008 sel_val_i  in  2  clock-source select.
REQ-009 dly_val_i  in  dq_group_p*dly_width_p  per-group DQS delay; group g occupies slice g.
REQ-010 cfg_v_o  out  1  configuration write valid.
REQ-011 cfg_ready_i  in  1  tag master accepts the write.
REQ-012 cfg_target_o  out  bsg_dmc_cfg_target_e  destination tag client.
REQ-013 cfg_idx_o  out  clog2(dq_group_p), minimum 1 bit  delay-group index; 0 for non-DLY targets.
REQ-014 cfg_data_o  out  dly_width_p  payload, zero-extended.
REQ-015 busy_o  out  1  sequence in progress.
REQ-016 done_o  out  1  sequence complete.

Function
REQ-017 SHALL latch osc_val_i, sel_val_i and dly_val_i on the cycle start_i is accepted; changes to these inputs afterwards SHALL have no effect until the next start.
REQ-018 start_i SHALL be accepted only in IDLE or DONE; it SHALL be ignored while busy_o=1.
REQ-019 SHALL use states IDLE, WRITE, SETTLE and DONE; an accepted start SHALL move the block to WRITE on the next cycle, with the write counter set to 0.
REQ-020 In WRITE, the block SHALL issue this ordered write list:
  - OSC_RESET←1, DLY_RESET←1, DS_RESET←1, OSC_RESET←0, DLY_RESET←0
  - OSC←osc, OSC_TRIG←1, OSC_TRIG←0, SEL←sel
  - for g=0..dq_group_p-1: DLY[g]←dly[g], DLY_TRIG[g]←1, DLY_TRIG[g]←0
  - DS_RESET←0
  The total is 10+3*dq_group_p writes.
REQ-021 A write transfers on a cycle with cfg_v_o & cfg_ready_i; until then cfg_target_o, cfg_idx_o and cfg_data_o SHALL stay stable and cfg_v_o SHALL stay high.
REQ-022 After a non-final transfer, the next write SHALL be valid on the following cycle, with no bubble cycle.
REQ-023 The final transfer SHALL move the block to SETTLE and deassert cfg_v_o on the next cycle.
REQ-024 SETTLE SHALL last exactly settle_cycles_p cycles, then move to DONE.
REQ-025 busy_o SHALL be 1 in WRITE and SETTLE only.
REQ-026 done_o SHALL be 1 in DONE only, and SHALL hold until a new start is accepted.
REQ-027 A start accepted in DONE SHALL clear done_o and set busy_o on the next cycle.
REQ-028 cfg_v_o SHALL be 0 outside WRITE.
REQ-029 cfg_ready_i SHALL be ignored while cfg_v_o=0.

Reset
REQ-030 While reset_n_i=0, the block SHALL be in IDLE, with cfg_v_o=0, busy_o=0, done_o=0, cfg_target_o=OSC_RESET, cfg_idx_o=0, cfg_data_o=0 and all counters at 0, regardless of clk_i.
REQ-031 Reset asserted mid-sequence SHALL drop cfg_v_o combinationally-free but immediately (asynchronous clear), and SHALL NOT complete the pending write.
REQ-032 After reset_n_i rises, no write SHALL be issued until start_i is accepted.

Structure
REQ-033 bsg_dmc_cfg_target_e SHALL be defined in bsg_dmc_pkg with values OSC_RESET, DLY_RESET, DS_RESET, OSC, OSC_TRIG, SEL, DLY, DLY_TRIG.
REQ-034 The write-list decode (write index to target/idx/data) SHALL be a combinational function of the write counter and the latched settings, kept inside this module.
REQ-035 The SETTLE wait SHALL instantiate bsg_counter_clear_up as its single sub-module.
REQ-036 All flops SHALL use the asynchronous active-low reset.

Verification
REQ-037 dq_group_p=2, cfg_ready_i=1 constantly, start pulse: 16 writes on 16 consecutive cycles in REQ-020 order, then 16 SETTLE cycles, then done_o=1.
REQ-038 cfg_ready_i low for 3 cycles on write 6 (OSC←0x5A): target, data and cfg_v_o hold for 4 cycles, and sequence order is unchanged.
REQ-039 Change osc_val_i from 0x5A to 0x11 on the cycle after start: the OSC write carries 0x5A.
REQ-040 start_i pulsed during write 3 and again during SETTLE: both pulses are ignored, with exactly one sequence and one done.
REQ-041 reset_n_i dropped while write 12 is pending: cfg_v_o=0 and busy_o=0 immediately; after release and a new start, the sequence restarts from OSC_RESET←1.
REQ-042 Start issued in DONE with dly_val_i={0x20,0x10}: a second full sequence runs, with DLY[0]=0x10 and DLY[1]=0x20.
